// File: rtl/wb_register_file.sv
// Write-back stage and architectural register file for the 5-stage MIPS pipeline.
// Selects the write-back result and writes it into a 32x32 register file.
// Serves two decode read ports with same-cycle write-through bypass.
// Also exports the result, a write-valid flag, a retired-write counter and a debug port.
module wb_register_file #(
    parameter int DW   = 32,
    parameter int NREG = 32,
    parameter int CW   = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    RFWEW,
    input  logic                    MtoRFSelW,
    input  logic [DW-1:0]           DMOutW,
    input  logic [DW-1:0]           ALUOutW,
    input  logic [$clog2(NREG)-1:0] RFAW,
    input  logic [$clog2(NREG)-1:0] RFRA1,
    input  logic [$clog2(NREG)-1:0] RFRA2,
    output logic [DW-1:0]           RFRD1,
    output logic [DW-1:0]           RFRD2,
    output logic [DW-1:0]           ResultW,
    output logic                    WBValid,
    input  logic [$clog2(NREG)-1:0] DbgRA,
    output logic [DW-1:0]           DbgRD,
    output logic [CW-1:0]           WrCount
);

    localparam int AW = $clog2(NREG);
    localparam logic [AW-1:0] ZERO_ADDR = '0;
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

    logic [DW-1:0] regs [NREG];
    logic [CW-1:0] wr_count;

    // Result select and write qualification; $0 writes are never real writes.
    always_comb begin
        ResultW = MtoRFSelW ? DMOutW : ALUOutW;
        WBValid = RFWEW && (RFAW != ZERO_ADDR);
    end

    // Register array update; reset clears everything and swallows a colliding write.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (WBValid) begin
            regs[RFAW] <= ResultW;
        end
    end

    // Retired-write counter; wraps naturally at all-ones.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_count <= '0;
        end else if (WBValid) begin
            wr_count <= wr_count + CNT_ONE;
        end
    end

    // Decode read ports: $0 hardwired, same-cycle write is forwarded so the
    // decode stage sees it as if written in the first half of the cycle.
    always_comb begin
        RFRD1 = '0;
        RFRD2 = '0;
        if (RFRA1 != ZERO_ADDR) begin
            RFRD1 = (WBValid && (RFRA1 == RFAW)) ? ResultW : regs[RFRA1];
        end
        if (RFRA2 != ZERO_ADDR) begin
            RFRD2 = (WBValid && (RFRA2 == RFAW)) ? ResultW : regs[RFRA2];
        end
    end

    // Debug port shows committed state only, never the in-flight write.
    always_comb begin
        DbgRD = '0;
        if (DbgRA != ZERO_ADDR) begin
            DbgRD = regs[DbgRA];
        end
    end

    assign WrCount = wr_count;

endmodule

// File: tb/tb_wb_register_file.sv
// Self-checking bench for wb_register_file: vector table plus hand sequences
// for reset, reset collision and counter wrap (second instance with CW=4).
module tb_wb_register_file;

    logic        clk;
    logic        rst;
    logic        rfwew;
    logic        mtorfsel;
    logic [31:0] dmout;
    logic [31:0] aluout;
    logic [4:0]  rfaw;
    logic [4:0]  rfra1;
    logic [4:0]  rfra2;
    logic [31:0] rfrd1;
    logic [31:0] rfrd2;
    logic [31:0] result;
    logic        wbvalid;
    logic [4:0]  dbgra;
    logic [31:0] dbgrd;
    logic [31:0] wrcount;

    logic [31:0] s_rfrd1, s_rfrd2, s_result, s_dbgrd;
    logic        s_wbvalid;
    logic [3:0]  s_wrcount;

    int passed = 0;
    int total  = 0;

    wb_register_file #(.DW(32), .NREG(32), .CW(32)) dut (
        .CLK(clk), .RST(rst), .RFWEW(rfwew), .MtoRFSelW(mtorfsel),
        .DMOutW(dmout), .ALUOutW(aluout), .RFAW(rfaw),
        .RFRA1(rfra1), .RFRA2(rfra2), .RFRD1(rfrd1), .RFRD2(rfrd2),
        .ResultW(result), .WBValid(wbvalid), .DbgRA(dbgra), .DbgRD(dbgrd),
        .WrCount(wrcount)
    );

    wb_register_file #(.DW(32), .NREG(32), .CW(4)) dut_small (
        .CLK(clk), .RST(rst), .RFWEW(rfwew), .MtoRFSelW(mtorfsel),
        .DMOutW(dmout), .ALUOutW(aluout), .RFAW(rfaw),
        .RFRA1(rfra1), .RFRA2(rfra2), .RFRD1(s_rfrd1), .RFRD2(s_rfrd2),
        .ResultW(s_result), .WBValid(s_wbvalid), .DbgRA(dbgra), .DbgRD(s_dbgrd),
        .WrCount(s_wrcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        sel;
        logic [31:0] dm;
        logic [31:0] alu;
        logic [4:0]  aw;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [4:0]  dbg;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [31:0] e_res;
        logic        e_valid;
        logic [31:0] e_dbg;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rfwew = 1'b0; mtorfsel = 1'b0; dmout = '0; aluout = '0;
        rfaw = '0; rfra1 = '0; rfra2 = '0; dbgra = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        //            we sel dm            alu           aw  ra1 ra2 dbg  rd1           rd2           res           v  dbg           cnt
        vecs[0] = '{1'b1, 1'b0, 32'h0,        32'h0000_1234, 5'd5,  5'd5,  5'd0,  5'd5,  32'h1234,     32'h0,        32'h1234,     1'b1, 32'h0,        32'd0};
        vecs[1] = '{1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0,        5'd6,  5'd5,  5'd6,  5'd5,  32'h1234,     32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 32'h1234,     32'd1};
        vecs[2] = '{1'b1, 1'b0, 32'h0,        32'h11,        5'd7,  5'd6,  5'd0,  5'd6,  32'hDEAD_BEEF, 32'h0,        32'h11,       1'b1, 32'hDEAD_BEEF, 32'd2};
        vecs[3] = '{1'b1, 1'b0, 32'h0,        32'h22,        5'd7,  5'd7,  5'd7,  5'd7,  32'h22,       32'h22,       32'h22,       1'b1, 32'h11,       32'd3};
        vecs[4] = '{1'b0, 1'b0, 32'h0,        32'h33,        5'd7,  5'd7,  5'd5,  5'd7,  32'h22,       32'h1234,     32'h33,       1'b0, 32'h22,       32'd4};
        vecs[5] = '{1'b1, 1'b0, 32'h0,        32'hFFFF_FFFF, 5'd0,  5'd0,  5'd7,  5'd0,  32'h0,        32'h22,       32'hFFFF_FFFF, 1'b0, 32'h0,        32'd4};
        vecs[6] = '{1'b0, 1'b0, 32'h0,        32'h0,         5'd0,  5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        1'b0, 32'h0,        32'd4};
        vecs[7] = '{1'b1, 1'b1, 32'hAAAA_5555, 32'h1,        5'd31, 5'd31, 5'd6,  5'd31, 32'hAAAA_5555, 32'hDEAD_BEEF, 32'hAAAA_5555, 1'b1, 32'h0,        32'd4};
        vecs[8] = '{1'b1, 1'b0, 32'h0,        32'h77,        5'd31, 5'd30, 5'd31, 5'd31, 32'h0,        32'h77,       32'h77,       1'b1, 32'hAAAA_5555, 32'd5};
        vecs[9] = '{1'b0, 1'b0, 32'h0,        32'h0,         5'd0,  5'd31, 5'd7,  5'd31, 32'h77,       32'h22,       32'h0,        1'b0, 32'h77,       32'd6};

        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        check("reset_wrcount", wrcount, 32'd0);
        for (int a = 0; a < 32; a++) begin
            dbgra = a[4:0];
            #1;
            check($sformatf("reset_dbg%0d", a), dbgrd, 32'h0);
        end

        // Vector table: combinational outputs before the edge, then commit
        for (int i = 0; i < 10; i++) begin
            rfwew = vecs[i].we; mtorfsel = vecs[i].sel; dmout = vecs[i].dm;
            aluout = vecs[i].alu; rfaw = vecs[i].aw; rfra1 = vecs[i].ra1;
            rfra2 = vecs[i].ra2; dbgra = vecs[i].dbg;
            #2;
            check($sformatf("v%0d_rd1", i), rfrd1, vecs[i].e_rd1);
            check($sformatf("v%0d_rd2", i), rfrd2, vecs[i].e_rd2);
            check($sformatf("v%0d_result", i), result, vecs[i].e_res);
            check($sformatf("v%0d_wbvalid", i), {31'b0, wbvalid}, {31'b0, vecs[i].e_valid});
            check($sformatf("v%0d_dbg", i), dbgrd, vecs[i].e_dbg);
            check($sformatf("v%0d_wrcount", i), wrcount, vecs[i].e_cnt);
            tick();
        end
        idle();
        #1;
        check("post_vec_wrcount", wrcount, 32'd6);

        // Unknown address with write disabled must not write or count
        rfaw = 5'bxxxxx;
        aluout = 32'hBAD0_BAD0;
        #1;
        check("x_addr_wbvalid", {31'b0, wbvalid}, 32'd0);
        tick();
        rfaw = 5'd0;
        dbgra = 5'd31;
        #1;
        check("x_addr_reg31", dbgrd, 32'h77);
        check("x_addr_wrcount", wrcount, 32'd6);

        // Reset colliding with a write: write discarded, nothing counted
        rst = 1'b1; rfwew = 1'b1; rfaw = 5'd3; aluout = 32'h55; mtorfsel = 1'b0;
        tick();
        rst = 1'b0;
        idle();
        dbgra = 5'd3;
        #1;
        check("collide_reg3", dbgrd, 32'h0);
        check("collide_wrcount", wrcount, 32'd0);
        dbgra = 5'd6;
        #1;
        check("collide_reg6_cleared", dbgrd, 32'h0);

        // First write after reset lands normally
        rfwew = 1'b1; rfaw = 5'd3; aluout = 32'h99;
        tick();
        idle();
        dbgra = 5'd3; rfra1 = 5'd3;
        #1;
        check("post_reset_reg3", dbgrd, 32'h99);
        check("post_reset_rd1", rfrd1, 32'h99);
        check("post_reset_wrcount", wrcount, 32'd1);

        // Counter wrap on the CW=4 instance; last write to the same register wins
        do_reset();
        for (int i = 0; i < 16; i++) begin
            rfwew = 1'b1; rfaw = 5'd1; aluout = 32'(i + 100);
            tick();
        end
        idle();
        dbgra = 5'd1;
        #1;
        check("wrap16_small_cnt", {28'b0, s_wrcount}, 32'd0);
        check("wrap16_big_cnt", wrcount, 32'd16);
        check("wrap16_last_wins", dbgrd, 32'd115);
        rfwew = 1'b1; rfaw = 5'd2; aluout = 32'h5;
        tick();
        idle();
        #1;
        check("wrap17_small_cnt", {28'b0, s_wrcount}, 32'd1);
        check("wrap17_big_cnt", wrcount, 32'd17);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
